gerador_de_pulsos_botoes: RTL
=============================

// Module: gerador_de_pulsos_botoes
// PURPOSE
//  Conditions raw push-button pins into clean one-cycle pulses for the RPN sequencer (enter_pulso, executar_pulso).
//  Per channel: 2-FF synchronizer, counter-based debouncer, press-edge detector. Channels are fully independent.
//  Sits between the FPGA KEY pins and the control unit; one pulso bit per key press.
// PARAMETERS
//  NUM_BOTOES        2          number of independent button channels (>=1)
//  ATIVO_BAIXO       1          1: pin low = pressed (board KEYs); 0: pin high = pressed
//  DEBOUNCE_CICLOS   1000000    consecutive differing samples needed to accept a new level (20 ms @ 50 MHz; >=1)
//  ATRASO_REPETICAO  25000000   cycles held before first auto-repeat pulse (used only with macro)
//  PERIODO_REPETICAO 10000000   cycles between subsequent auto-repeat pulses (used only with macro)
// PORTS
//  clk       in   1           system clock
//  reset_n   in   1           asynchronous reset, active low
//  botoes    in   NUM_BOTOES  raw asynchronous button pins
//  pulso     out  NUM_BOTOES  one-cycle press pulse per channel (bit0 -> enter, bit1 -> executar)
//  estavel   out  NUM_BOTOES  debounced level, 1 = pressed (polarity normalised)
// BEHAVIOUR
//  Reset (async, reset_n=0): sync FFs load released level; estavel=0; pulso=0; all counters=0.
//  Sync: s = normalised output of 2nd synchronizer FF. A pin change reaches s after 2 clock edges.
//  Debounce counter cnt, width $clog2(DEBOUNCE_CICLOS+1):
//   - s == estavel -> cnt <= 0.
//   - s != estavel, cnt <  DEBOUNCE_CICLOS-1 -> cnt <= cnt+1.
//   - s != estavel, cnt == DEBOUNCE_CICLOS-1 -> estavel <= s, cnt <= 0.
//   - Any glitch back to the estavel level restarts the count from 0.
//  Press pulse: pulso[i] <= 1 on the same edge estavel[i] goes 0->1; otherwise 0. Release produces no pulse.
//  Latency: pin held pressed from edge k -> pulso high for exactly one cycle after edge k+1+DEBOUNCE_CICLOS.
//  Button held: exactly one pulse (macro absent). Bounces shorter than DEBOUNCE_CICLOS: no pulse, no estavel change.
//  Simultaneous presses on several channels: each pulses independently, possibly in the same cycle.
//  Button held through reset: after reset_n rises, one pulse after DEBOUNCE_CICLOS+2 cycles (estavel starts released).
//  Reset mid-debounce: count discarded; no pulse from the aborted count.
// CONFIGURATION
//  Macro GERADOR_PULSOS_AUTO_REPETICAO_EN:
//   - Defined: per-channel repeat counter; while estavel=1, extra pulse after ATRASO_REPETICAO cycles
//     following the press pulse, then every PERIODO_REPETICAO cycles; counter cleared when estavel=0 or reset.
//   - Undefined: no repeat logic; exactly one pulse per debounced press; repeat parameters ignored.
// STRUCTURE
//  Package pacote_botoes: NIVEL_SOLTO/NIVEL_PRESSIONADO constants, default DEBOUNCE_CICLOS,
//   repeat defaults, function for counter width.
//  Sub-module debounce_canal: one channel (sync, debounce, edge, optional repeat);
//   top instantiates NUM_BOTOES copies via generate.
// TESTING (bench: DEBOUNCE_CICLOS=4, ATRASO_REPETICAO=10, PERIODO_REPETICAO=5, ATIVO_BAIXO=1)
//  1 reset_n=0 with botoes=2'b00 -> pulso=0, estavel=0; after release, one pulse per channel 6 cycles later.
//  2 botoes[0] 1->0 held 20 cycles -> pulso[0]=1 exactly one cycle, 6 cycles after the edge; estavel[0]=1 until release+6.
//  3 botoes[1] toggles 0/1 every 2 cycles for 30 cycles -> pulso[1] never asserts, estavel[1] stays 0.
//  4 both pins fall in same cycle -> pulso=2'b11 in one cycle, then 2'b00.
//  5 reset_n pulsed low at cnt=2 of a press -> no pulse; pin still held -> pulse 6 cycles after reset release.
//  6 macro defined, botoes[0] held 40 cycles -> pulso[0] at t, t+10, t+15, t+20, ...; none after release.

Source files
------------

// File: rtl/gerador_de_pulsos_botoes_pkg.sv
// Shared constants and helpers for the push-button pulse generator.
// Repeat defaults apply only when GERADOR_PULSOS_AUTO_REPETICAO_EN is defined.
package pacote_botoes;

  // Normalised level: internal logic always sees 1 = pressed
  localparam logic NIVEL_SOLTO       = 1'b0;
  localparam logic NIVEL_PRESSIONADO = 1'b1;

  localparam int DEBOUNCE_CICLOS_PADRAO   = 1000000;
  localparam int ATRASO_REPETICAO_PADRAO  = 25000000;
  localparam int PERIODO_REPETICAO_PADRAO = 10000000;

  function automatic int largura_contador(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int maximo(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gerador_de_pulsos_botoes_debounce_canal.sv
// One button channel: 2-FF synchronizer, counter debouncer, press-edge pulse.
// Optional auto-repeat under macro GERADOR_PULSOS_AUTO_REPETICAO_EN.
module debounce_canal
  import pacote_botoes::*;
#(
  parameter int ATIVO_BAIXO       = 1,
  parameter int DEBOUNCE_CICLOS   = DEBOUNCE_CICLOS_PADRAO,
  parameter int ATRASO_REPETICAO  = ATRASO_REPETICAO_PADRAO,
  parameter int PERIODO_REPETICAO = PERIODO_REPETICAO_PADRAO
) (
  input  logic clk,
  input  logic reset_n,
  input  logic botao,
  output logic pulso,
  output logic estavel
);

  localparam logic PINO_SOLTO = (ATIVO_BAIXO != 0) ? 1'b1 : 1'b0;
  localparam int   LARG       = largura_contador(DEBOUNCE_CICLOS);
  localparam logic [LARG-1:0] LIMITE = LARG'(DEBOUNCE_CICLOS - 1);

  if (ATRASO_REPETICAO < 1 || PERIODO_REPETICAO < 1) begin : g_erro_repeticao
    $error("debounce_canal: repeat parameters must be >= 1");
  end

  logic [1:0]      sinc;
  logic            s;
  logic [LARG-1:0] cnt;
  logic            aceita;
  logic            pulso_press;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sinc <= {2{PINO_SOLTO}};
    else          sinc <= {sinc[0], botao};
  end

  assign s      = (sinc[1] == PINO_SOLTO) ? NIVEL_SOLTO : NIVEL_PRESSIONADO;
  assign aceita = (s != estavel) && (cnt == LIMITE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      estavel     <= NIVEL_SOLTO;
      pulso_press <= 1'b0;
    end else begin
      pulso_press <= aceita && (s == NIVEL_PRESSIONADO);
      if (s == estavel) begin
        cnt <= '0;
      end else if (aceita) begin
        estavel <= s;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef GERADOR_PULSOS_AUTO_REPETICAO_EN
  localparam int LARG_REP = largura_contador(maximo(ATRASO_REPETICAO, PERIODO_REPETICAO));

  logic [LARG_REP-1:0] rep_cnt;
  logic [LARG_REP-1:0] limite_rep;
  logic                primeira;
  logic                pulso_rep;

  assign limite_rep = primeira ? LARG_REP'(ATRASO_REPETICAO - 1)
                               : LARG_REP'(PERIODO_REPETICAO - 1);

  // A debounce acceptance while pressed is the release: suppress any repeat on that edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt   <= '0;
      primeira  <= 1'b1;
      pulso_rep <= 1'b0;
    end else begin
      pulso_rep <= 1'b0;
      if (estavel == NIVEL_SOLTO || aceita) begin
        rep_cnt  <= '0;
        primeira <= 1'b1;
      end else if (rep_cnt == limite_rep) begin
        rep_cnt   <= '0;
        primeira  <= 1'b0;
        pulso_rep <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

  assign pulso = pulso_press | pulso_rep;
`else
  assign pulso = pulso_press;
`endif

endmodule

// File: rtl/gerador_de_pulsos_botoes.sv
// Conditions raw KEY pins into one-cycle press pulses, one independent channel per button.
// Define GERADOR_PULSOS_AUTO_REPETICAO_EN to enable hold-to-repeat pulses.
module gerador_de_pulsos_botoes
  import pacote_botoes::*;
#(
  parameter int NUM_BOTOES        = 2,
  parameter int ATIVO_BAIXO       = 1,
  parameter int DEBOUNCE_CICLOS   = DEBOUNCE_CICLOS_PADRAO,
  parameter int ATRASO_REPETICAO  = ATRASO_REPETICAO_PADRAO,
  parameter int PERIODO_REPETICAO = PERIODO_REPETICAO_PADRAO
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_BOTOES-1:0] botoes,
  output logic [NUM_BOTOES-1:0] pulso,
  output logic [NUM_BOTOES-1:0] estavel
);

  if (NUM_BOTOES < 1 || DEBOUNCE_CICLOS < 1) begin : g_erro_parametros
    $error("gerador_de_pulsos_botoes: NUM_BOTOES and DEBOUNCE_CICLOS must be >= 1");
  end

  for (genvar i = 0; i < NUM_BOTOES; i++) begin : g_canal
    debounce_canal #(
      .ATIVO_BAIXO      (ATIVO_BAIXO),
      .DEBOUNCE_CICLOS  (DEBOUNCE_CICLOS),
      .ATRASO_REPETICAO (ATRASO_REPETICAO),
      .PERIODO_REPETICAO(PERIODO_REPETICAO)
    ) u_canal (
      .clk    (clk),
      .reset_n(reset_n),
      .botao  (botoes[i]),
      .pulso  (pulso[i]),
      .estavel(estavel[i])
    );
  end

endmodule
